// File: rtl/frame_header_gen.sv
// frame_header_gen: emits the ProRes frame-container prefix, the frame header and
// the optional luma/chroma quantisation matrices as (value, bit-length) beats
// towards the bit packer under a valid/ready handshake.
module frame_header_gen #(
  parameter int          VAL_W             = 64,
  parameter int          COEF_PER_BEAT     = 1,
  parameter logic [31:0] ENCODER_ID        = 32'h4c617663,
  parameter logic [7:0]  BITSTREAM_VERSION = 8'h00,
  parameter bit          FLUSH_AT_END      = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      horizontal,
  input  logic [15:0]      vertical,
  input  logic [1:0]       chroma_format,
  input  logic [1:0]       interlace_mode,
  input  logic [3:0]       aspect_ratio_information,
  input  logic [3:0]       frame_rate_code,
  input  logic [3:0]       alpha_channel_type,
  input  logic [7:0]       color_primaries,
  input  logic [7:0]       transfer_characteristic,
  input  logic [7:0]       matrix_coefficients,
  input  logic             load_luma_qmat,
  input  logic             load_chroma_qmat,
  input  logic [511:0]     y_qmat,
  input  logic [511:0]     c_qmat,
  output logic             busy,
  output logic             output_enable,
  input  logic             out_ready,
  output logic [VAL_W-1:0] val,
  output logic [VAL_W-1:0] size_of_bit,
  output logic             flush_bit,
  output logic             done
);

  localparam int         BEATS_PER_MAT  = 64 / COEF_PER_BEAT;
  localparam int         MAT_BITS       = 8 * COEF_PER_BEAT;
  localparam logic [5:0] LAST_FIELD_IDX = 6'd22;
  localparam logic [5:0] LAST_MAT_IDX   = 6'(BEATS_PER_MAT - 1);

  typedef enum logic [2:0] {IDLE, FIELDS, LUMA, CHROMA, DONE} state_t;

  typedef struct packed {
    logic [15:0]  horizontal;
    logic [15:0]  vertical;
    logic [1:0]   chromaFormat;
    logic [1:0]   interlaceMode;
    logic [3:0]   aspectRatio;
    logic [3:0]   frameRateCode;
    logic [3:0]   alphaChannelType;
    logic [7:0]   colorPrimaries;
    logic [7:0]   transferChar;
    logic [7:0]   matrixCoef;
    logic         loadLuma;
    logic         loadChroma;
    logic [511:0] yQmat;
    logic [511:0] cQmat;
  } params_t;

  state_t              state_q, state_d;
  logic [5:0]          beatIdx_q, beatIdx_d;
  params_t             params_q, params_d;

  logic                beatValid;
  logic                beatAccept;
  logic                lastMatBeat;
  logic [15:0]         headerSize;
  logic [31:0]         fieldVal;
  logic [6:0]          fieldLen;
  logic [511:0]        curMat;
  logic [MAT_BITS-1:0] matWord;

  assign beatValid   = (state_q == FIELDS) || (state_q == LUMA) || (state_q == CHROMA);
  assign beatAccept  = beatValid && out_ready;
  assign lastMatBeat = (beatIdx_q == LAST_MAT_IDX);
  assign headerSize  = 16'd20 + (params_q.loadLuma ? 16'd64 : 16'd0)
                              + (params_q.loadChroma ? 16'd64 : 16'd0);
  assign curMat      = (state_q == CHROMA) ? params_q.cQmat : params_q.yQmat;

  // Sequencer: latch parameters on start, advance the beat index on each accepted beat.
  always_comb begin
    state_d   = state_q;
    beatIdx_d = beatIdx_q;
    params_d  = params_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          params_d.horizontal       = horizontal;
          params_d.vertical         = vertical;
          params_d.chromaFormat     = chroma_format;
          params_d.interlaceMode    = interlace_mode;
          params_d.aspectRatio      = aspect_ratio_information;
          params_d.frameRateCode    = frame_rate_code;
          params_d.alphaChannelType = alpha_channel_type;
          params_d.colorPrimaries   = color_primaries;
          params_d.transferChar     = transfer_characteristic;
          params_d.matrixCoef       = matrix_coefficients;
          params_d.loadLuma         = load_luma_qmat;
          params_d.loadChroma       = load_chroma_qmat;
          params_d.yQmat            = y_qmat;
          params_d.cQmat            = c_qmat;
          beatIdx_d                 = '0;
          state_d                   = FIELDS;
        end
      end
      FIELDS: begin
        if (beatAccept) begin
          if (beatIdx_q == LAST_FIELD_IDX) begin
            beatIdx_d = '0;
            if (params_q.loadLuma)        state_d = LUMA;
            else if (params_q.loadChroma) state_d = CHROMA;
            else                          state_d = DONE;
          end else begin
            beatIdx_d = beatIdx_q + 6'd1;
          end
        end
      end
      LUMA: begin
        if (beatAccept) begin
          if (lastMatBeat) begin
            beatIdx_d = '0;
            state_d   = params_q.loadChroma ? CHROMA : DONE;
          end else begin
            beatIdx_d = beatIdx_q + 6'd1;
          end
        end
      end
      CHROMA: begin
        if (beatAccept) begin
          if (lastMatBeat) begin
            beatIdx_d = '0;
            state_d   = DONE;
          end else begin
            beatIdx_d = beatIdx_q + 6'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Header field table: value and bit length of each of the 23 fixed beats.
  always_comb begin
    fieldVal = '0;
    fieldLen = '0;
    case (beatIdx_q)
      6'd0:  begin fieldVal = 32'h0;                               fieldLen = 7'd32; end
      6'd1:  begin fieldVal = 32'h69637066;                        fieldLen = 7'd32; end
      6'd2:  begin fieldVal = 32'(headerSize);                     fieldLen = 7'd16; end
      6'd3:  begin fieldVal = 32'h0;                               fieldLen = 7'd8;  end
      6'd4:  begin fieldVal = 32'(BITSTREAM_VERSION);              fieldLen = 7'd8;  end
      6'd5:  begin fieldVal = ENCODER_ID;                          fieldLen = 7'd32; end
      6'd6:  begin fieldVal = 32'(params_q.horizontal);            fieldLen = 7'd16; end
      6'd7:  begin fieldVal = 32'(params_q.vertical);              fieldLen = 7'd16; end
      6'd8:  begin fieldVal = 32'(params_q.chromaFormat);          fieldLen = 7'd2;  end
      6'd9:  begin fieldVal = 32'h0;                               fieldLen = 7'd2;  end
      6'd10: begin fieldVal = 32'(params_q.interlaceMode);         fieldLen = 7'd2;  end
      6'd11: begin fieldVal = 32'h0;                               fieldLen = 7'd2;  end
      6'd12: begin fieldVal = 32'(params_q.aspectRatio);           fieldLen = 7'd4;  end
      6'd13: begin fieldVal = 32'(params_q.frameRateCode);         fieldLen = 7'd4;  end
      6'd14: begin fieldVal = 32'(params_q.colorPrimaries);        fieldLen = 7'd8;  end
      6'd15: begin fieldVal = 32'(params_q.transferChar);          fieldLen = 7'd8;  end
      6'd16: begin fieldVal = 32'(params_q.matrixCoef);            fieldLen = 7'd8;  end
      6'd17: begin fieldVal = 32'h4;                               fieldLen = 7'd4;  end
      6'd18: begin fieldVal = 32'(params_q.alphaChannelType);      fieldLen = 7'd4;  end
      6'd19: begin fieldVal = 32'h0;                               fieldLen = 7'd8;  end
      6'd20: begin fieldVal = 32'h0;                               fieldLen = 7'd6;  end
      6'd21: begin fieldVal = 32'(params_q.loadLuma);              fieldLen = 7'd1;  end
      6'd22: begin fieldVal = 32'(params_q.loadChroma);            fieldLen = 7'd1;  end
      default: begin fieldVal = 32'h0;                             fieldLen = 7'd0;  end
    endcase
  end

  // Matrix beat packing: lowest coefficient index lands in the most-significant byte.
  always_comb begin
    matWord = '0;
    for (int i = 0; i < COEF_PER_BEAT; i++) begin
      matWord      = matWord << 8;
      matWord[7:0] = curMat[{6'(int'(beatIdx_q) * COEF_PER_BEAT + i), 3'b000} +: 8];
    end
  end

  // Output drive: beat data only while a header beat is offered, zero otherwise.
  always_comb begin
    busy          = (state_q != IDLE);
    done          = (state_q == DONE);
    output_enable = beatValid;
    val           = '0;
    size_of_bit   = '0;
    flush_bit     = 1'b0;
    if (state_q == FIELDS) begin
      val[31:0]        = fieldVal;
      size_of_bit[6:0] = fieldLen;
      flush_bit        = FLUSH_AT_END && (beatIdx_q == LAST_FIELD_IDX)
                         && !params_q.loadLuma && !params_q.loadChroma;
    end else if ((state_q == LUMA) || (state_q == CHROMA)) begin
      val[MAT_BITS-1:0] = matWord;
      size_of_bit[6:0]  = 7'(MAT_BITS);
      flush_bit         = FLUSH_AT_END && lastMatBeat
                          && ((state_q == CHROMA) || !params_q.loadChroma);
    end
  end

  // State, beat index and latched picture parameters; async reset aborts any header.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      beatIdx_q <= '0;
      params_q  <= '0;
    end else begin
      state_q   <= state_d;
      beatIdx_q <= beatIdx_d;
      params_q  <= params_d;
    end
  end

endmodule
